// File: rtl/fir_ternary_param.sv
// Ternary-coefficient (+1/-1/0) FIR with valid handshake, 2-stage adder pipeline,
// double-buffered coefficients and synchronous flush. Optional macro FIR_TERN_SAT_EN saturates the output.
module fir_ternary_param #(
  parameter int TAPS   = 10,
  parameter int DATA_W = 8,
  parameter int OUT_W  = DATA_W + $clog2(TAPS),
  parameter int CIDX_W = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] in,
  input  logic                     in_valid,
  input  logic                     coef_w_en,
  input  logic [CIDX_W-1:0]        coef_num,
  input  logic [1:0]               coef_val,
  input  logic                     coef_commit,
  output logic signed [OUT_W-1:0]  out,
  output logic                     out_valid
);

  localparam int FW   = DATA_W + $clog2(TAPS) + 1;
  localparam int HALF = TAPS / 2;

  logic signed [DATA_W-1:0] x_r [TAPS];
  logic [1:0]               shadow_r [TAPS];
  logic [1:0]               active_r [TAPS];
  logic [1:0]               shadow_next_s [TAPS];
  logic                     wr_ok_s;
  logic                     v0_r;
  logic                     v1_r;
  logic signed [FW-1:0]     psum_lo_s;
  logic signed [FW-1:0]     psum_hi_s;
  logic signed [FW-1:0]     psum_lo_r;
  logic signed [FW-1:0]     psum_hi_r;
  logic signed [FW-1:0]     total_s;
  logic signed [OUT_W-1:0]  out_next_s;
  logic signed [OUT_W-1:0]  out_r;
  logic                     out_valid_r;

  // Codes 00 and 10 both contribute nothing.
  function automatic logic signed [FW-1:0] tern_term(input logic [1:0] code,
                                                     input logic signed [DATA_W-1:0] x);
    logic signed [FW-1:0] xe;
    xe = FW'(x);
    case (code)
      2'b01:   tern_term = xe;
      2'b11:   tern_term = -xe;
      default: tern_term = '0;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [FW-1:0] v);
`ifdef FIR_TERN_SAT_EN
    logic signed [FW-1:0] sat_max;
    logic signed [FW-1:0] sat_min;
    sat_max = {{(FW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    sat_min = {{(FW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if (v > sat_max) begin
      reduce_out = sat_max[OUT_W-1:0];
    end else if (v < sat_min) begin
      reduce_out = sat_min[OUT_W-1:0];
    end else begin
      reduce_out = v[OUT_W-1:0];
    end
`else
    reduce_out = v[OUT_W-1:0];
`endif
  endfunction

  assign wr_ok_s = coef_w_en && (int'(coef_num) < TAPS);

  // Post-write shadow bank, so a same-cycle write is included in a commit.
  always_comb begin
    shadow_next_s = shadow_r;
    if (wr_ok_s) begin
      shadow_next_s[coef_num] = coef_val;
    end else begin
      shadow_next_s = shadow_r;
    end
  end

  // Split tap sum into lower and upper halves for the first adder stage.
  always_comb begin
    psum_lo_s = '0;
    psum_hi_s = '0;
    for (int i = 0; i < TAPS; i++) begin
      if (i < HALF) begin
        psum_lo_s = psum_lo_s + tern_term(active_r[i], x_r[i]);
      end else begin
        psum_hi_s = psum_hi_s + tern_term(active_r[i], x_r[i]);
      end
    end
  end

  // Second adder stage and output width reduction.
  always_comb begin
    total_s    = psum_lo_r + psum_hi_r;
    out_next_s = reduce_out(total_s);
  end

  // Shadow and active coefficient banks; clr leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) begin
        shadow_r[i] <= 2'b00;
        active_r[i] <= 2'b00;
      end
    end else begin
      shadow_r <= shadow_next_s;
      if (coef_commit) begin
        active_r <= shadow_next_s;
      end else begin
        active_r <= active_r;
      end
    end
  end

  // Delay line; v0_r marks a freshly shifted-in sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) x_r[i] <= '0;
      v0_r <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < TAPS; i++) x_r[i] <= '0;
      v0_r <= 1'b0;
    end else if (in_valid) begin
      x_r[0] <= in;
      for (int i = 1; i < TAPS; i++) x_r[i] <= x_r[i-1];
      v0_r <= 1'b1;
    end else begin
      v0_r <= 1'b0;
    end
  end

  // Stage-1 partial sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_lo_r <= '0;
      psum_hi_r <= '0;
      v1_r      <= 1'b0;
    end else if (clr) begin
      psum_lo_r <= '0;
      psum_hi_r <= '0;
      v1_r      <= 1'b0;
    end else begin
      v1_r <= v0_r;
      if (v0_r) begin
        psum_lo_r <= psum_lo_s;
        psum_hi_r <= psum_hi_s;
      end
    end
  end

  // Output register; value is held between pulses and across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else if (clr) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        out_r <= out_next_s;
      end
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fir_ternary_param.sv
// Randomized self-checking bench for fir_ternary_param: a default instance and an OUT_W=10
// instance share stimulus and are compared each cycle against a sample-history reference model.
module tb_fir_ternary_param;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clr_s;
  logic signed [7:0] in_s;
  logic              in_valid_s;
  logic              coef_w_en_s;
  logic [3:0]        coef_num_s;
  logic [1:0]        coef_val_s;
  logic              coef_commit_s;
  logic signed [11:0] out_s;
  logic              out_valid_s;
  logic signed [9:0] out10_s;
  logic              out10_valid_s;

  int errors = 0;
  int checks = 0;

  fir_ternary_param dut (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .in(in_s), .in_valid(in_valid_s),
    .coef_w_en(coef_w_en_s), .coef_num(coef_num_s), .coef_val(coef_val_s),
    .coef_commit(coef_commit_s), .out(out_s), .out_valid(out_valid_s)
  );

  fir_ternary_param #(.OUT_W(10)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr_s), .in(in_s), .in_valid(in_valid_s),
    .coef_w_en(coef_w_en_s), .coef_num(coef_num_s), .coef_val(coef_val_s),
    .coef_commit(coef_commit_s), .out(out10_s), .out_valid(out10_valid_s)
  );

  always #5 clk = ~clk;

  // Reference model: coefficient banks as weights, sample history, outputs pending by due edge.
  typedef struct { int due; int val; } pend_t;
  int    shadow_m [10];
  int    active_m [10];
  int    hist_m [10];
  pend_t pend_q [$];
  int    edge_n = 0;
  bit    exp_vld_m = 1'b0;
  int    exp_out12_m = 0;
  int    exp_out10_m = 0;
  bit    capture_on = 1'b0;
  int    got_q [$];

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int code_weight(input logic [1:0] code);
    if (code == 2'b01) return 1;
    if (code == 2'b11) return -1;
    return 0;
  endfunction

  function automatic int reduce_w(input int v, input int w);
    int m;
    int r;
    m = 1 << w;
`ifdef FIR_TERN_SAT_EN
    if (v > m/2 - 1) return m/2 - 1;
    if (v < -(m/2)) return -(m/2);
    return v;
`else
    r = v % m;
    if (r < 0) r += m;
    if (r >= m/2) r -= m;
    return r;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 10; i++) begin
      shadow_m[i] = 0; active_m[i] = 0; hist_m[i] = 0;
    end
    pend_q.delete();
    exp_vld_m = 1'b0; exp_out12_m = 0; exp_out10_m = 0;
  endfunction

  function automatic void model_edge();
    int acc;
    edge_n++;
    if (coef_w_en_s && coef_num_s < 4'd10) shadow_m[coef_num_s] = code_weight(coef_val_s);
    if (coef_commit_s) active_m = shadow_m;
    exp_vld_m = 1'b0;
    if (clr_s) begin
      for (int i = 0; i < 10; i++) hist_m[i] = 0;
      pend_q.delete();
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
        exp_vld_m   = 1'b1;
        exp_out12_m = reduce_w(pend_q[0].val, 12);
        exp_out10_m = reduce_w(pend_q[0].val, 10);
        void'(pend_q.pop_front());
      end
      if (in_valid_s) begin
        for (int i = 9; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = int'(in_s);
        acc = 0;
        for (int i = 0; i < 10; i++) acc += active_m[i] * hist_m[i];
        pend_q.push_back('{due: edge_n + 2, val: acc});
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("out_valid", int'(out_valid_s), int'(exp_vld_m));
    check_val("out", int'(out_s), exp_out12_m);
    check_val("sat_out_valid", int'(out10_valid_s), int'(exp_vld_m));
    check_val("sat_out", int'(out10_s), exp_out10_m);
    if (capture_on && out_valid_s) got_q.push_back(int'(out_s));
  endtask

  task automatic set_idle();
    clr_s = 1'b0; in_valid_s = 1'b0; coef_w_en_s = 1'b0; coef_commit_s = 1'b0;
  endtask

  task automatic load_all(input logic [1:0] code, input bit do_commit);
    for (int i = 0; i < 10; i++) begin
      coef_w_en_s = 1'b1; coef_num_s = 4'(i); coef_val_s = code;
      tick();
    end
    coef_w_en_s = 1'b0;
    if (do_commit) begin
      coef_commit_s = 1'b1; tick(); coef_commit_s = 1'b0;
    end
  endtask

  task automatic load_pattern();
    logic [1:0] pat [10];
    pat = '{2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 10; i++) begin
      coef_w_en_s = 1'b1; coef_num_s = 4'(i); coef_val_s = pat[i];
      tick();
    end
    coef_w_en_s = 1'b0;
    coef_commit_s = 1'b1; tick(); coef_commit_s = 1'b0;
  endtask

  task automatic impulse_run(input string tag);
    int exp_seq [10];
    exp_seq = '{1, -1, 0, 1, -1, 0, 1, -1, 0, 1};
    got_q.delete();
    capture_on = 1'b1;
    in_valid_s = 1'b1; in_s = 8'sd1; tick();
    in_s = 8'sd0;
    repeat (9) tick();
    in_valid_s = 1'b0;
    repeat (3) tick();
    capture_on = 1'b0;
    check_val({tag, "_count"}, got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) check_val(tag, got_q[i], exp_seq[i]);
  endtask

  task automatic stream_step(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid_s = 1'b1; in_s = 8'($urandom); tick();
    end
    in_valid_s = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_s = 8'sd0; coef_num_s = 4'd0; coef_val_s = 2'b00;
    set_idle();
    model_reset();
    #1;
    check_val("reset_out", int'(out_s), 0);
    check_val("reset_out_valid", int'(out_valid_s), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();

    load_pattern();
    impulse_run("impulse");

    // Full-scale steps
    load_all(2'b01, 1'b1);
    in_valid_s = 1'b1; in_s = 8'sd127;
    repeat (14) tick();
    in_valid_s = 1'b0;
    check_val("pos_step", int'(out_s), 1270);
`ifdef FIR_TERN_SAT_EN
    check_val("pos_step_w10", int'(out10_s), 511);
`else
    check_val("pos_step_w10", int'(out10_s), 246);
`endif
    load_all(2'b11, 1'b1);
    in_valid_s = 1'b1; in_s = -8'sd128;
    repeat (14) tick();
    in_valid_s = 1'b0;
    check_val("neg_step", int'(out_s), 1280);

    // Shadow isolation, then commit together with a sample
    load_all(2'b01, 1'b1);
    stream_step(6);
    for (int i = 0; i < 10; i++) begin
      in_valid_s = 1'b1; in_s = 8'($urandom);
      coef_w_en_s = 1'b1; coef_num_s = 4'(i); coef_val_s = 2'b00;
      tick();
    end
    coef_w_en_s = 1'b0;
    stream_step(3);
    in_valid_s = 1'b1; in_s = 8'sd100; coef_commit_s = 1'b1; tick();
    coef_commit_s = 1'b0;
    stream_step(1);
    for (int i = 0; i < 4; i++) begin
      in_valid_s = 1'b1; in_s = 8'($urandom); tick();
      check_val("post_commit_zero", int'(out_s), 0);
    end
    in_valid_s = 1'b0;

    // Out-of-range writes must not land anywhere
    for (int n = 10; n < 16; n++) begin
      coef_w_en_s = 1'b1; coef_num_s = 4'(n); coef_val_s = 2'b01; tick();
    end
    coef_w_en_s = 1'b0;
    coef_commit_s = 1'b1; tick(); coef_commit_s = 1'b0;
    stream_step(12);
    check_val("oor_write", int'(out_s), 0);

    // Flush mid-stream, then a clean impulse
    load_pattern();
    stream_step(5);
    clr_s = 1'b1; in_valid_s = 1'b1; in_s = 8'sd55; tick();
    check_val("clr_gap0", int'(out_valid_s), 0);
    clr_s = 1'b0; in_valid_s = 1'b0; tick();
    check_val("clr_gap1", int'(out_valid_s), 0);
    impulse_run("post_clr_impulse");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_s          = 8'($urandom);
      in_valid_s    = ($urandom % 4) != 0;
      coef_w_en_s   = ($urandom % 3) == 0;
      coef_num_s    = 4'($urandom);
      coef_val_s    = 2'($urandom);
      coef_commit_s = ($urandom % 8) == 0;
      clr_s         = ($urandom % 32) == 0;
      tick();
    end
    set_idle();

    // Asynchronous reset mid-stream
    load_all(2'b01, 1'b1);
    in_valid_s = 1'b1; in_s = 8'sd127;
    repeat (6) tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_out", int'(out_s), 0);
    check_val("async_rst_valid", int'(out_valid_s), 0);
    check_val("async_rst_sat_out", int'(out10_s), 0);
    model_reset();
    set_idle();
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) tick();
    load_pattern();
    impulse_run("post_rst_impulse");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
